// File: rtl/matrix_mult_seq.sv
// Sequencer computing C = A x B (2x2) by time-sharing one external multiplier.
// Optional ack timeout with sticky err: define MATSEQ_ACK_TIMEOUT_EN.
module matrix_mult_seq #(
   parameter int DATA_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      btnC,
   input  logic                      start,
   input  logic [4*DATA_W-1:0]       mat_a,
   input  logic [4*DATA_W-1:0]       mat_b,
   output logic                      mul_req,
   output logic [DATA_W-1:0]         mul_x,
   output logic [DATA_W-1:0]         mul_y,
   input  logic                      mul_ack,
   input  logic [2*DATA_W-1:0]       mul_p,
   output logic [4*(2*DATA_W+1)-1:0] res,
   output logic                      busy,
   output logic                      done,
   output logic [3:0]                matrix_loc,
   output logic                      err
);

   localparam int RW = 2*DATA_W+1;

   typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_t;

   state_t              state;
   logic [4*DATA_W-1:0] a_q;
   logic [4*DATA_W-1:0] b_q;
   logic [1:0]          idx;
   logic [RW-1:0]       acc;

   // A[i][k] with i taken from the element index
   function automatic logic [DATA_W-1:0] a_el(
      input logic [4*DATA_W-1:0] m,
      input logic [1:0]          id,
      input logic                k
   );
      return m[(2*int'(id[1])+int'(k))*DATA_W +: DATA_W];
   endfunction

   // B[k][j] with j taken from the element index
   function automatic logic [DATA_W-1:0] b_el(
      input logic [4*DATA_W-1:0] m,
      input logic [1:0]          id,
      input logic                k
   );
      return m[(2*int'(k)+int'(id[0]))*DATA_W +: DATA_W];
   endfunction

`ifdef MATSEQ_ACK_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT+1);
   logic [CW-1:0] wcnt;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (btnC) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         idx        <= '0;
         acc        <= '0;
         res        <= '0;
         mul_req    <= 1'b0;
         mul_x      <= '0;
         mul_y      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         matrix_loc <= 4'h0;
`ifdef MATSEQ_ACK_TIMEOUT_EN
         wcnt       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q        <= mat_a;
                  b_q        <= mat_b;
                  idx        <= 2'd0;
                  state      <= REQ0;
                  mul_req    <= 1'b1;
                  mul_x      <= a_el(mat_a, 2'd0, 1'b0);
                  mul_y      <= b_el(mat_b, 2'd0, 1'b0);
                  busy       <= 1'b1;
                  matrix_loc <= 4'ha;
`ifdef MATSEQ_ACK_TIMEOUT_EN
                  wcnt       <= '0;
                  err_q      <= 1'b0;
`endif
               end
            end
            REQ0: begin
               if (mul_ack) begin
                  acc   <= RW'(mul_p);
                  state <= REQ1;
                  mul_x <= a_el(a_q, idx, 1'b1);
                  mul_y <= b_el(b_q, idx, 1'b1);
`ifdef MATSEQ_ACK_TIMEOUT_EN
                  wcnt  <= '0;
`endif
               end
            end
            REQ1: begin
               if (mul_ack) begin
                  res[int'(idx)*RW +: RW] <= acc + RW'(mul_p);
`ifdef MATSEQ_ACK_TIMEOUT_EN
                  wcnt <= '0;
`endif
                  if (idx == 2'd3) begin
                     state   <= DONE;
                     mul_req <= 1'b0;
                     mul_x   <= '0;
                     mul_y   <= '0;
                     done    <= 1'b1;
                  end else begin
                     idx        <= idx + 2'd1;
                     state      <= REQ0;
                     mul_x      <= a_el(a_q, idx + 2'd1, 1'b0);
                     mul_y      <= b_el(b_q, idx + 2'd1, 1'b0);
                     matrix_loc <= 4'ha + {2'b00, idx} + 4'd1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               matrix_loc <= 4'h0;
            end
            default: state <= IDLE;
         endcase
`ifdef MATSEQ_ACK_TIMEOUT_EN
         // a stalled multiplier aborts the run without a done pulse
         if ((state == REQ0 || state == REQ1) && !mul_ack) begin
            if (wcnt == CW'(TIMEOUT-1)) begin
               wcnt       <= '0;
               err_q      <= 1'b1;
               state      <= IDLE;
               mul_req    <= 1'b0;
               mul_x      <= '0;
               mul_y      <= '0;
               busy       <= 1'b0;
               matrix_loc <= 4'h0;
            end else begin
               wcnt <= wcnt + CW'(1);
            end
         end
`endif
      end
   end

endmodule
